// File: rtl/seg_pkg.sv
// Shared types and sizing helpers for the 4-digit 7-segment scan controller.
package seg_pkg;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;
  localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

  // Counter width for a period of n cycles; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_update_buf.sv
// Pending/active double buffer for display values; ready drops while a value is pending.
// Accepted data reaches active only on a swap request; nothing is overwritten or dropped.
module seg_update_buf
  import seg_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [VALUE_W-1:0]    upd_value,
  input  logic [NUM_DIGITS-1:0] upd_dots,
  input  logic                  swap,
  output logic [VALUE_W-1:0]    active_value,
  output logic [NUM_DIGITS-1:0] active_dots
);

  logic [VALUE_W-1:0]    pend_value;
  logic [NUM_DIGITS-1:0] pend_dots;
  logic                  pend_full;

  assign upd_ready = !pend_full;

  // Accept and swap are mutually exclusive: ready is low whenever pend_full is set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_value   <= '0;
      pend_dots    <= '0;
      pend_full    <= 1'b0;
      active_value <= '0;
      active_dots  <= '0;
    end else if (upd_valid && upd_ready) begin
      pend_value <= upd_value;
      pend_dots  <= upd_dots;
      pend_full  <= 1'b1;
    end else if (swap && pend_full) begin
      active_value <= pend_value;
      active_dots  <= pend_dots;
      pend_full    <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display: BLANK gap, then DRIVE dwell per digit.
// New values swap in at the frame boundary; optional brightness dimming under SEG_SCAN_DIM_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 16384,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]            brightness,
`endif
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [VALUE_W-1:0]    upd_value,
  input  logic [NUM_DIGITS-1:0] upd_dots,
  output logic [1:0]            digit_sel,
  output logic [NIBBLE_W-1:0]   nibble,
  output logic                  dot,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_strobe
);

  localparam int DW = cnt_w(DWELL_CYCLES);
  localparam int BW = cnt_w(BLANK_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  scan_state_t           state, state_nxt;
  logic [1:0]            digit_sel_nxt;
  logic [DW-1:0]         dwell_cnt, dwell_nxt;
  logic [BW-1:0]         blank_cnt, blank_nxt;
  logic [VALUE_W-1:0]    active_value;
  logic [NUM_DIGITS-1:0] active_dots;
  logic                  drive_on;

  seg_update_buf u_buf (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_value    (upd_value),
    .upd_dots     (upd_dots),
    .swap         (frame_strobe),
    .active_value (active_value),
    .active_dots  (active_dots)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= BLANK;
      digit_sel <= 2'd0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_nxt;
      digit_sel <= digit_sel_nxt;
      dwell_cnt <= dwell_nxt;
      blank_cnt <= blank_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    digit_sel_nxt = digit_sel;
    dwell_nxt     = dwell_cnt;
    blank_nxt     = blank_cnt;
    case (state)
      BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          state_nxt = DRIVE;
          dwell_nxt = '0;
        end else begin
          blank_nxt = blank_cnt + 1'b1;
        end
      end
      DRIVE: begin
        if (dwell_cnt == DWELL_LAST) begin
          state_nxt     = BLANK;
          blank_nxt     = '0;
          digit_sel_nxt = (digit_sel == 2'd3) ? 2'd0 : digit_sel + 2'd1;
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  assign frame_strobe = (state == DRIVE) && (dwell_cnt == DWELL_LAST) && (digit_sel == 2'd3);

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] bright_q;

  // Latched on entry to DRIVE so a brightness change never reshapes a dwell in progress.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bright_q <= 4'd0;
    end else if (state == BLANK && blank_cnt == BLANK_LAST) begin
      bright_q <= brightness;
    end
  end

  assign drive_on = (state == DRIVE) && (dwell_cnt[DW-1 -: 4] <= bright_q);
`else
  assign drive_on = (state == DRIVE);
`endif

  assign digit_en = drive_on ? (4'b1000 >> digit_sel) : 4'b0000;
  assign dot      = active_dots[digit_sel];

  // Digit 0 is the leftmost, held in the top nibble.
  always_comb begin
    nibble = active_value[15:12];
    case (digit_sel)
      2'd0: nibble = active_value[15:12];
      2'd1: nibble = active_value[11:8];
      2'd2: nibble = active_value[7:4];
      2'd3: nibble = active_value[3:0];
      default: nibble = active_value[15:12];
    endcase
  end

endmodule
